// File: rtl/samsun_execute_if.sv
// Execute-stage bundle for Samsun_Core: decode-side request signals plus writeback/redirect returns.
// The slave modport is the execute stage; the master modport is the decode/fetch side.
interface samsun_execute_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 13
);
    logic [CTRL_W-1:0] exec_ctrl_signal_i;
    logic [XLEN-1:0]   exec_operand1_i;
    logic [XLEN-1:0]   exec_operand2_i;
    logic [XLEN-1:0]   exec_rs2_i;
    logic [4:0]        exec_rd_addr_i;
    logic [XLEN-1:0]   exec_pc_i;
    logic              exec_ready_o;
    logic              exec_flush_o;
    logic              br_taken_o;
    logic [XLEN-1:0]   br_tgt_addr_o;
    logic [4:0]        wb_rd_addr_o;
    logic [XLEN-1:0]   wb_rd_o;
    logic              wb_rd_en_o;

    modport slave (
        input  exec_ctrl_signal_i, exec_operand1_i, exec_operand2_i, exec_rs2_i,
               exec_rd_addr_i, exec_pc_i,
        output exec_ready_o, exec_flush_o, br_taken_o, br_tgt_addr_o,
               wb_rd_addr_o, wb_rd_o, wb_rd_en_o
    );

    modport master (
        output exec_ctrl_signal_i, exec_operand1_i, exec_operand2_i, exec_rs2_i,
               exec_rd_addr_i, exec_pc_i,
        input  exec_ready_o, exec_flush_o, br_taken_o, br_tgt_addr_o,
               wb_rd_addr_o, wb_rd_o, wb_rd_en_o
    );
endinterface

// File: rtl/samsun_execute.sv
// Samsun_Core execute stage: RV32I ALU, branch/jump resolution, serial 1-bit/cycle shifter.
// Define SAMSUN_EXEC_FAST_SHIFT_EN to replace the serial shifter with a single-cycle barrel shifter.
module samsun_execute #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 13
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    samsun_execute_if.slave       exec_if
);
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;
    localparam logic [3:0] OP_PASS = 4'd10;

    typedef enum logic {IDLE, SHIFT} state_t;

    function automatic logic [XLEN-1:0] alu_calc(input logic [3:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic [XLEN-1:0] res;
        res = a + b;
        case (op)
            OP_SUB:  res = a - b;
            OP_SLT:  res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: res = {{(XLEN-1){1'b0}}, (a < b)};
            OP_XOR:  res = a ^ b;
            OP_OR:   res = a | b;
            OP_AND:  res = a & b;
            OP_PASS: res = b;
`ifdef SAMSUN_EXEC_FAST_SHIFT_EN
            OP_SLL:  res = a << b[4:0];
            OP_SRL:  res = a >> b[4:0];
            OP_SRA:  res = $signed(a) >>> b[4:0];
`else
            // Only reached with shamt==0; nonzero amounts go through the serial path
            OP_SLL, OP_SRL, OP_SRA: res = a;
`endif
            default: res = a + b;
        endcase
        return res;
    endfunction

    function automatic logic br_cond(input logic [2:0] f3,
                                     input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) <  $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a <  b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    logic [CTRL_W-1:0] w_ctrl;
    logic [3:0]        w_alu_op;
    logic              w_valid, w_rd_we, w_branch, w_jal, w_jalr;
    logic [2:0]        w_funct3;
    logic              w_ready, w_accept, w_wb_ok, w_start_shift;
    logic              w_unused_rsvd;
    logic [XLEN-1:0]   w_jalr_sum, w_shift_next;
    state_t            r_state, w_state_nxt;

    logic [XLEN-1:0]   r_shift_val;
    logic [4:0]        r_cnt;
    logic [3:0]        r_shift_op;
    logic [4:0]        r_shift_rd;
    logic              r_shift_we;
    logic              r_wb_en, r_taken, r_flush;
    logic [4:0]        r_wb_addr;
    logic [XLEN-1:0]   r_wb_data, r_tgt;

    assign w_ctrl        = exec_if.exec_ctrl_signal_i;
    assign w_alu_op      = w_ctrl[3:0];
    assign w_valid       = w_ctrl[4];
    assign w_rd_we       = w_ctrl[5];
    assign w_branch      = w_ctrl[6];
    assign w_funct3      = w_ctrl[9:7];
    assign w_jal         = w_ctrl[10];
    assign w_jalr        = w_ctrl[11];
    assign w_unused_rsvd = w_ctrl[12];

    assign w_ready    = (r_state == IDLE);
    assign w_accept   = w_valid && w_ready && !r_flush;
    assign w_wb_ok    = w_rd_we && (exec_if.exec_rd_addr_i != 5'd0);
    assign w_jalr_sum = exec_if.exec_operand1_i + exec_if.exec_operand2_i;

`ifdef SAMSUN_EXEC_FAST_SHIFT_EN
    assign w_start_shift = 1'b0;
`else
    logic w_is_shift;
    assign w_is_shift    = (w_alu_op == OP_SLL) || (w_alu_op == OP_SRL) || (w_alu_op == OP_SRA);
    assign w_start_shift = w_accept && !w_branch && !w_jal && !w_jalr && w_is_shift &&
                           (exec_if.exec_operand2_i[4:0] != 5'd0);
`endif

    always_comb begin
        w_shift_next = r_shift_val >> 1;
        case (r_shift_op)
            OP_SLL:  w_shift_next = r_shift_val << 1;
            OP_SRA:  w_shift_next = {r_shift_val[XLEN-1], r_shift_val[XLEN-1:1]};
            default: w_shift_next = r_shift_val >> 1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start_shift) w_state_nxt = SHIFT;
            SHIFT:   if (r_cnt == 5'd1) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_shift_val <= '0;
            r_cnt       <= '0;
            r_shift_op  <= '0;
            r_shift_rd  <= '0;
            r_shift_we  <= 1'b0;
            r_wb_en     <= 1'b0;
            r_taken     <= 1'b0;
            r_flush     <= 1'b0;
            r_wb_addr   <= '0;
            r_wb_data   <= '0;
            r_tgt       <= '0;
        end else begin
            r_wb_en <= 1'b0;
            r_taken <= 1'b0;
            r_flush <= 1'b0;
            if (r_state == SHIFT) begin
                r_cnt <= r_cnt - 5'd1;
                if (r_cnt == 5'd1) begin
                    r_wb_en <= r_shift_we;
                    if (r_shift_we) begin
                        r_wb_data <= w_shift_next;
                        r_wb_addr <= r_shift_rd;
                    end
                end else begin
                    r_shift_val <= w_shift_next;
                end
            end else if (w_accept) begin
                if (w_start_shift) begin
                    r_shift_val <= exec_if.exec_operand1_i;
                    r_cnt       <= exec_if.exec_operand2_i[4:0];
                    r_shift_op  <= w_alu_op;
                    r_shift_rd  <= exec_if.exec_rd_addr_i;
                    r_shift_we  <= w_wb_ok;
                end else if (w_jal || w_jalr) begin
                    r_taken <= 1'b1;
                    r_flush <= 1'b1;
                    r_tgt   <= w_jal ? (exec_if.exec_pc_i + exec_if.exec_operand2_i)
                                     : {w_jalr_sum[XLEN-1:1], 1'b0};
                    r_wb_en <= w_wb_ok;
                    if (w_wb_ok) begin
                        r_wb_data <= exec_if.exec_pc_i + 32'd4;
                        r_wb_addr <= exec_if.exec_rd_addr_i;
                    end
                end else if (w_branch) begin
                    if (br_cond(w_funct3, exec_if.exec_operand1_i, exec_if.exec_rs2_i)) begin
                        r_taken <= 1'b1;
                        r_flush <= 1'b1;
                        r_tgt   <= exec_if.exec_pc_i + exec_if.exec_operand2_i;
                    end
                end else begin
                    r_wb_en <= w_wb_ok;
                    if (w_wb_ok) begin
                        r_wb_data <= alu_calc(w_alu_op, exec_if.exec_operand1_i,
                                              exec_if.exec_operand2_i);
                        r_wb_addr <= exec_if.exec_rd_addr_i;
                    end
                end
            end
        end
    end

    assign exec_if.exec_ready_o  = w_ready;
    assign exec_if.exec_flush_o  = r_flush;
    assign exec_if.br_taken_o    = r_taken;
    assign exec_if.br_tgt_addr_o = r_tgt;
    assign exec_if.wb_rd_addr_o  = r_wb_addr;
    assign exec_if.wb_rd_o       = r_wb_data;
    assign exec_if.wb_rd_en_o    = r_wb_en;
endmodule
